// File: rtl/int8_dot_sequencer.sv
// Sequences a multi-chunk int8 dot-product job through an external combinational MAC,
// accumulating partial sums modulo 2^24 and presenting the result with a valid/ready handshake.
module int8_dot_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_chunks,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [263:0]     a_vec,
    input  logic [263:0]     b_vec,
    output logic             mac_en,
    output logic [263:0]     mac_a,
    output logic [263:0]     mac_b,
    output logic [23:0]      mac_psum_in,
    input  logic [23:0]      mac_psum_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      result,
    output logic [7:0]       out_scale,
    output logic [CNT_W-1:0] chunk_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [23:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num;
    logic [7:0]       r_scale;

    logic w_run;
    logic w_go;
    logic w_accept;
    logic w_last;
    logic w_handshake;

    assign w_run       = (r_state == RUN);
    assign w_go        = (r_state == IDLE) && start && !abort && (num_chunks != {CNT_W{1'b0}});
    assign w_accept    = in_valid && in_ready;
    assign w_last      = w_accept && (r_cnt == (r_num - CNT_W'(1)));
    assign w_handshake = (r_state == DONE) && out_ready && !abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort outranks both beat acceptance and the result handshake
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Accumulator, beat counter, latched job length and scale capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= 24'd0;
            r_cnt   <= {CNT_W{1'b0}};
            r_num   <= {CNT_W{1'b0}};
            r_scale <= 8'd0;
        end else if (abort) begin
            r_acc   <= 24'd0;
            r_cnt   <= {CNT_W{1'b0}};
            r_scale <= 8'd0;
        end else if (w_go) begin
            r_num <= num_chunks;
            r_acc <= 24'd0;
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_acc <= mac_psum_out;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == {CNT_W{1'b0}}) begin
                r_scale <= a_vec[7:0];
            end
        end else if (w_handshake) begin
            // Clearing here keeps result and chunk_cnt at zero while idle
            r_acc <= 24'd0;
            r_cnt <= {CNT_W{1'b0}};
        end
    end

    assign busy        = (r_state != IDLE);
    assign in_ready    = w_run && !abort;
    assign out_valid   = (r_state == DONE);
    assign result      = r_acc;
    assign out_scale   = r_scale;
    assign chunk_cnt   = r_cnt;
    assign mac_en      = w_run;
    assign mac_a       = w_run ? a_vec : 264'd0;
    assign mac_b       = w_run ? b_vec : 264'd0;
    assign mac_psum_in = w_run ? r_acc : 24'd0;

endmodule

// File: tb/tb_int8_dot_sequencer.sv
// Self-checking bench: behavioural int8 MAC on the mac_* ports, job-level reference
// dot products, directed scenarios plus randomized jobs.
module tb_int8_dot_sequencer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_chunks;
    logic             abort;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [263:0]     a_vec;
    logic [263:0]     b_vec;
    logic             mac_en;
    logic [263:0]     mac_a;
    logic [263:0]     mac_b;
    logic [23:0]      mac_psum_in;
    logic [23:0]      mac_psum_out;
    logic             out_valid;
    logic             out_ready;
    logic [23:0]      result;
    logic [7:0]       out_scale;
    logic [CNT_W-1:0] chunk_cnt;

    int checks = 0;
    int errors = 0;

    logic [263:0] ja [16];
    logic [263:0] jb [16];

    always #5 clk = ~clk;

    int8_dot_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_chunks(num_chunks), .abort(abort),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_psum_in(mac_psum_in),
        .mac_psum_out(mac_psum_out), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_scale(out_scale), .chunk_cnt(chunk_cnt)
    );

    // External int8 MAC: psum + sum of unsigned byte products over bytes 1..32
    function automatic logic [23:0] mac_model(input logic [23:0] p, input logic [263:0] a,
                                              input logic [263:0] b);
        int s;
        s = int'(p);
        for (int k = 1; k <= 32; k++) s += int'(a[8*k +: 8]) * int'(b[8*k +: 8]);
        return s[23:0];
    endfunction

    assign mac_psum_out = mac_model(mac_psum_in, mac_a, mac_b);

    // Reference: dot product of the first n chunks of the job, modulo 2^24
    function automatic logic [23:0] ref_dot(input int n);
        longint s;
        s = 0;
        for (int i = 0; i < n; i++)
            for (int k = 1; k <= 32; k++)
                s += longint'(ja[i][8*k +: 8]) * longint'(jb[i][8*k +: 8]);
        return s[23:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int idx, input logic [7:0] a0, input logic [7:0] av,
                        input logic [7:0] bv);
        ja[idx] = 264'd0;
        jb[idx] = 264'd0;
        ja[idx][7:0] = a0;
        for (int k = 1; k <= 32; k++) begin
            ja[idx][8*k +: 8] = av;
            jb[idx][8*k +: 8] = bv;
        end
    endtask

    task automatic fill_rand(input int idx);
        for (int k = 0; k <= 32; k++) begin
            ja[idx][8*k +: 8] = 8'($urandom);
            jb[idx][8*k +: 8] = 8'($urandom);
        end
    endtask

    task automatic send_beat(input int i);
        in_valid = 1'b1;
        a_vec    = ja[i];
        b_vec    = jb[i];
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_vec    = 264'd0;
        b_vec    = 264'd0;
    endtask

    task automatic start_job(input int n);
        start      = 1'b1;
        num_chunks = CNT_W'(n);
        @(posedge clk); #1;
        start      = 1'b0;
        num_chunks = '0;
    endtask

    task automatic do_job(input int n, input int gap, input int rdly, input bit restart,
                          input int known);
        logic [23:0] exp;
        exp = ref_dot(n);
        start_job(n);
        chk("busy_after_start", busy, 1);
        chk("cnt_after_start", chunk_cnt, 0);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            a_vec    = ja[i];
            b_vec    = jb[i];
            if (restart && i == 1) begin
                start      = 1'b1;
                num_chunks = CNT_W'(1);
            end
            #1;
            chk("in_ready_run", in_ready, 1);
            chk("mac_en_run", mac_en, 1);
            chk("mac_a_pass", {31'd0, mac_a === ja[i]}, 1);
            chk("psum_in_partial", mac_psum_in, ref_dot(i));
            @(posedge clk); #1;
            in_valid   = 1'b0;
            start      = 1'b0;
            num_chunks = '0;
            a_vec      = 264'd0;
            b_vec      = 264'd0;
            if (i < n - 1) chk("cnt_beat", chunk_cnt, i + 1);
        end
        chk("out_valid_lat1", out_valid, 1);
        chk("result", result, exp);
        if (known >= 0) chk("result_known", result, known);
        chk("out_scale", out_scale, ja[0][7:0]);
        chk("in_ready_done", in_ready, 0);
        chk("mac_en_done", mac_en, 0);
        chk("cnt_done", chunk_cnt, n);
        for (int r = 0; r < rdly; r++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, exp);
            chk("hold_busy", busy, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        chk("idle_result", result, 0);
        chk("idle_cnt", chunk_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_chunks = '0; abort = 1'b0;
        in_valid = 1'b0; a_vec = 264'd0; b_vec = 264'd0; out_ready = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_mac_en", mac_en, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic job
        for (int i = 0; i < 3; i++) fill(i, 8'h05, 8'd1, 8'd2);
        do_job(3, 0, 0, 1'b0, 192);

        // Backpressure: gapped input, consumer stalls 5 cycles
        do_job(3, 2, 5, 1'b0, 192);

        // Abort during the second beat
        for (int i = 0; i < 4; i++) fill(i, 8'h33, 8'd7, 8'd9);
        start_job(4);
        send_beat(0);
        in_valid = 1'b1; a_vec = ja[1]; b_vec = jb[1]; abort = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_cnt", chunk_cnt, 0);
        chk("abort_result", result, 0);
        chk("abort_scale", out_scale, 0);
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", out_valid, 0);
        end
        fill(0, 8'h01, 8'd1, 8'd1);
        do_job(1, 0, 0, 1'b0, 32);

        // Zero-length start is ignored; a start during RUN is ignored
        start = 1'b1; num_chunks = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_start_busy", busy, 0);
        for (int i = 0; i < 3; i++) fill_rand(i);
        do_job(3, 0, 1, 1'b1, -1);

        // Wrap-around of the 24-bit accumulator
        for (int i = 0; i < 9; i++) fill(i, 8'hFF, 8'hFF, 8'hFF);
        do_job(9, 0, 0, 1'b0, 1949984);

        // Reset mid-job
        for (int i = 0; i < 5; i++) fill_rand(i);
        start_job(5);
        send_beat(0);
        send_beat(1);
        in_valid = 1'b1; a_vec = ja[2]; b_vec = jb[2];
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_mac_en", mac_en, 0);
        chk("mrst_mac_a", {31'd0, |mac_a}, 0);
        chk("mrst_psum_in", mac_psum_in, 0);
        chk("mrst_result", result, 0);
        chk("mrst_cnt", chunk_cnt, 0);
        chk("mrst_scale", out_scale, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("post_rst_idle", busy, 0);
        fill(0, 8'h02, 8'd1, 8'd2);
        do_job(1, 0, 0, 1'b0, 64);

        // Randomized jobs
        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) fill_rand(i);
            do_job(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
